counter_seq_ctrl: RTL and testbench

Sequencing controller for the `counter` up/down counter block. It accepts count jobs over a start/busy/done interface and drives the counter's control inputs: `load_n`, `up_down`, `ce`, `data_load`. It watches the counter's `zero` and `max_count` flags to detect job completion. Supported jobs are one-shot or periodic count-down and count-up, with pause and abort.

---
 rtl/counter_seq_ctrl_if.sv | 31 +++
 rtl/counter_seq_ctrl.sv | 102 ++++++++++
 tb/tb_counter_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_if.sv
// Job and counter-control bundle for counter_seq_ctrl.
// master = job requester plus the counter's flags; slave = the controller.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] period;
  logic [7:0]       reps;
  logic             pause;
  logic             abort;
  logic             cnt_zero;
  logic             cnt_max;
  logic             cnt_load_n;
  logic             cnt_up_down;
  logic             cnt_ce;
  logic [WIDTH-1:0] cnt_data_load;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output start, mode, period, reps, pause, abort, cnt_zero, cnt_max,
    input  cnt_load_n, cnt_up_down, cnt_ce, cnt_data_load, busy, tick, done
  );

  modport slave (
    input  start, mode, period, reps, pause, abort, cnt_zero, cnt_max,
    output cnt_load_n, cnt_up_down, cnt_ce, cnt_data_load, busy, tick, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the up/down counter: runs one-shot or periodic
// count jobs, with pause and abort, and reports ticks and completion.
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_period;
  logic [7:0]       r_reps;
  logic [7:0]       r_rep_left;

  logic [1:0]       w_state_nxt;
  logic [7:0]       w_rep_left_nxt;
  logic             w_is_load;
  logic             w_is_run;
  logic             w_terminal;
  logic             w_accept;

  assign w_is_load  = (r_state == S_LOAD);
  assign w_is_run   = (r_state == S_RUN);
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  // mode bit 0 selects direction, and with it which end of the range terminates
  assign w_terminal = r_mode[0] ? bus.cnt_max : bus.cnt_zero;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_rep_left_nxt = r_rep_left;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_LOAD;
          w_rep_left_nxt = bus.reps;
        end
      end
      S_LOAD: begin
        w_state_nxt = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_terminal) begin
          if (!r_mode[1]) begin
            w_state_nxt = S_DONE;
          end else if (r_reps == 8'd0) begin
            w_state_nxt = S_LOAD;
          end else if (r_rep_left == 8'd1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_rep_left_nxt = r_rep_left - 8'd1;
            w_state_nxt    = S_LOAD;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_period   <= '0;
      r_reps     <= 8'd0;
      r_rep_left <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rep_left <= w_rep_left_nxt;
      if (w_accept) begin
        r_mode   <= bus.mode;
        r_period <= bus.period;
        r_reps   <= bus.reps;
      end
    end
  end

  // Abort suppresses the load strobe so a cancelled job leaves the counter alone.
  assign bus.cnt_load_n    = !(w_is_load && !bus.abort);
  assign bus.cnt_ce        = w_is_run && !w_terminal && !bus.pause && !bus.abort;
  assign bus.cnt_up_down   = (w_is_load || w_is_run) && r_mode[0];
  assign bus.cnt_data_load = r_period;
  assign bus.busy          = w_is_load || w_is_run;
  assign bus.tick          = w_is_run && w_terminal && !bus.abort;
  assign bus.done          = (r_state == S_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: behavioural counter plant, a
// job-level reference model, per-cycle control checks and a tick/done scoreboard.
module tb_counter_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int MAXC  = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(WIDTH)) bus();

  counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Counter plant: load has priority, flags are combinational from the register.
  logic [WIDTH-1:0] cnt = '0;
  always @(posedge clk) begin
    if (!bus.cnt_load_n)  cnt <= bus.cnt_data_load;
    else if (bus.cnt_ce)  cnt <= bus.cnt_up_down ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign bus.cnt_zero = (cnt == '0);
  assign bus.cnt_max  = (cnt == '1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-job stimulus knobs and expected per-cycle control, indexed by cycle relative to start.
  bit pm[MAXC];
  bit m_busy[MAXC];
  bit m_ld[MAXC];
  bit m_ce[MAXC];
  int ab_rel  = -1;
  int rs_rel  = -1;
  int end_rel = 0;

  // A job is a sequence of reps; each rep is one load cycle followed by run cycles
  // until `steps` un-paused cycles have been spent moving toward the end value.
  task automatic build_model(input int c0, input logic [1:0] mode, input int period, input int reps);
    int t, c, steps, n, rep;
    bit stop;
    n = mode[0] ? (2**WIDTH - 1 - period) : period;
    for (int i = 0; i < MAXC; i++) begin
      m_busy[i] = 1'b0;
      m_ld[i]   = 1'b0;
      m_ce[i]   = 1'b0;
    end
    t = 1; rep = 0; stop = 1'b0; c = 0;
    while (!stop) begin
      if (t >= MAXC - 2) begin
        $display("FAIL model_length: job longer than %0d cycles", MAXC);
        $fatal(1);
      end
      m_busy[t] = 1'b1;
      if (t == ab_rel) begin
        end_rel = t;
        stop    = 1'b1;
      end else begin
        m_ld[t] = 1'b1;
        c = t + 1;
        steps = 0;
        while (1) begin
          if (c >= MAXC - 2) begin
            $display("FAIL model_length: job longer than %0d cycles", MAXC);
            $fatal(1);
          end
          m_busy[c] = 1'b1;
          if (c == ab_rel) begin
            end_rel = c;
            stop    = 1'b1;
            break;
          end
          if (steps == n) break;
          if (!pm[c]) begin
            m_ce[c] = 1'b1;
            steps++;
          end
          c++;
        end
        if (!stop) begin
          exp_q.push_back('{is_done: 1'b0, cyc: c0 + c});
          rep++;
          if (!mode[1] || (reps != 0 && rep == reps)) begin
            exp_q.push_back('{is_done: 1'b1, cyc: c0 + c + 1});
            end_rel = c + 1;
            stop    = 1'b1;
          end else begin
            t = c + 1;
          end
        end
      end
    end
  endtask

  // Issue a job at the next negedge and check the control outputs every cycle
  // until one cycle after it ends; request fields carry garbage after cycle 0.
  task automatic run_job(input logic [1:0] mode, input int period, input int reps);
    int c0;
    @(negedge clk);
    c0 = cyc;
    build_model(c0, mode, period, reps);
    for (int k = 0; k <= end_rel + 1; k++) begin
      if (k > 0) @(negedge clk);
      bus.start = (k == 0) || (k == rs_rel && k <= end_rel);
      if (k == 0) begin
        bus.mode   = mode;
        bus.period = period[WIDTH-1:0];
        bus.reps   = reps[7:0];
      end else begin
        bus.mode   = 2'($urandom);
        bus.period = WIDTH'($urandom);
        bus.reps   = 8'($urandom);
      end
      bus.pause = pm[k];
      bus.abort = (k == ab_rel);
      #1;
      check("busy",    int'(bus.busy),        int'(m_busy[k]));
      check("load_n",  int'(bus.cnt_load_n),  int'(!m_ld[k]));
      check("ce",      int'(bus.cnt_ce),      int'(m_ce[k]));
      check("up_down", int'(bus.cnt_up_down), m_busy[k] ? int'(mode[0]) : 0);
      if (k > 0) check("data_load", int'(bus.cnt_data_load), period);
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy",      int'(bus.busy),          0);
    check("rst_load_n",    int'(bus.cnt_load_n),    1);
    check("rst_ce",        int'(bus.cnt_ce),        0);
    check("rst_up_down",   int'(bus.cnt_up_down),   0);
    check("rst_data_load", int'(bus.cnt_data_load), 0);
    check("rst_tick",      int'(bus.tick),          0);
    check("rst_done",      int'(bus.done),          0);
  endtask

  task automatic clear_knobs();
    for (int i = 0; i < MAXC; i++) pm[i] = 1'b0;
    ab_rel = -1;
    rs_rel = -1;
  endtask

  // Scoreboard monitor: every tick/done the DUT presents must match the next expected event.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && (bus.tick || bus.done)) begin : mon
      ev_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'({bus.tick, bus.done}), 0);
      end else begin
        e = exp_q.pop_front();
        check(e.is_done ? "done_cycle" : "tick_cycle", cyc, e.cyc);
        check("event_kind", int'(bus.done), int'(e.is_done));
        if (bus.tick) check("ce_on_tick", int'(bus.cnt_ce), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] r_mode;
    int r_period, r_reps;

    bus.start = 1'b0; bus.mode = 2'd0; bus.period = '0; bus.reps = 8'd0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    clear_knobs();

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Reset mid-RUN: one-shot down from 10, reset held across cycles 4 and 5.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.period = 4'd10; bus.reps = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);

    // Directed cases.
    run_job(2'b00, 5, 1);
    run_job(2'b01, 13, 0);
    run_job(2'b00, 0, 0);
    run_job(2'b01, 15, 0);
    run_job(2'b10, 2, 3);
    run_job(2'b11, 14, 2);
    for (int i = 4; i <= 6; i++) pm[i] = 1'b1;
    run_job(2'b00, 10, 0);
    clear_knobs();
    ab_rel = 20;
    rs_rel = 6;
    run_job(2'b10, 3, 0);
    clear_knobs();

    // Randomized jobs with pauses, stray starts and occasional aborts.
    repeat (40) begin
      r_mode   = 2'($urandom);
      r_period = $urandom_range(0, 2**WIDTH - 1);
      r_reps   = $urandom_range(0, 3);
      for (int i = 0; i < MAXC; i++) pm[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0 || (r_mode[1] && r_reps == 0))
        ab_rel = $urandom_range(1, 60);
      else
        ab_rel = -1;
      rs_rel = $urandom_range(1, 20);
      run_job(r_mode, r_period, r_reps);
    end
    clear_knobs();

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
